// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard/stall unit.
// Contents:
//   - REG_ADDR_W  : register-specifier width.
//   - stage_rec_t : the per-stage shadow record.
//   - STAGE_NOP   : the all-zero record used for bubbles and for reset.
//   - rec_writes  : true when a record will really write the register file.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

  localparam stage_rec_t STAGE_NOP = '{1'b0, {REG_ADDR_W{1'b0}}, 1'b0, 1'b0};

  // A record only writes back when it holds a real instruction.
  function automatic logic rec_writes(input stage_rec_t rec);
    return rec.valid & rec.reg_write;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_stage_reg.sv
// One shadow pipeline stage register.
// Behaviour:
//   - Synchronous active-low clear.
//   - When en_i=0 the record holds.
//   - When en_i=1 it loads d_i, or loads a NOP if bubble_i=1.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   en_i             advance enable (pipeline not frozen)
//   bubble_i         load STAGE_NOP instead of d_i on advance
//   d_i              record from the previous stage
//   q_o              current record of this stage
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       bubble_i,
  input  stage_rec_t d_i,
  output stage_rec_t q_o
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  // Next record: hold, bubble or load.
  always_comb begin
    rec_d = rec_q;
    if (en_i) begin
      if (bubble_i) begin
        rec_d = STAGE_NOP;
      end else begin
        rec_d = d_i;
      end
    end else begin
      rec_d = rec_q;
    end
  end

  // Record register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_q <= STAGE_NOP;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign q_o = rec_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Producer-side hazard unit for the 5-stage pipeline.
//
// Function:
//   - Shadows the destination-register state of the EX, MEM and WB stages.
//   - From that state, drives the rd/RegWrite values the forwarding unit
//     consumes.
//   - Detects load-use hazards that forwarding cannot resolve.
//   - Drives the PC/IF-ID stall, ID/EX bubble and branch flush controls.
//   - Counts load-use stall cycles in a saturating counter.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_valid, id_rs, id_rt     ID instruction and its source registers
//   id_uses_rt                 ID instruction really reads rt
//   id_rd, id_reg_write        ID destination and its write enable
//   id_mem_read                ID instruction is a load
//   branch_taken, mem_ready    branch redirect and memory-ready freeze
//   pc_write, if_id_write      front-end enables
//   if_id_flush, id_ex_bubble  squash controls
//   ID_EX_rd .. MEM_WB_RegWrite  shadow-stage outputs
//   stall_count                saturating load-use stall cycle count
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   branch_taken,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic [REG_ADDR_W-1:0]  ID_EX_rd,
  output logic [REG_ADDR_W-1:0]  EX_MEM_rd,
  output logic                   EX_MEM_RegWrite,
  output logic [REG_ADDR_W-1:0]  MEM_WB_rd,
  output logic                   MEM_WB_RegWrite,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_rec_t id_rec_s;
  stage_rec_t s_ex_s;
  stage_rec_t s_mem_s;
  stage_rec_t s_wb_s;
  logic       load_use_s;
  logic       ex_bubble_s;

  logic [STALL_CNT_W-1:0] cnt_d;
  logic [STALL_CNT_W-1:0] cnt_q;

  assign id_rec_s = '{1'b1, id_rd, id_reg_write, id_mem_read};

  // A load still in EX cannot forward its data to ID. A load that targets
  // register 0 never creates a dependency.
  assign load_use_s = s_ex_s.valid && s_ex_s.mem_read && s_ex_s.reg_write &&
                      (s_ex_s.rd != {REG_ADDR_W{1'b0}}) && id_valid &&
                      ((s_ex_s.rd == id_rs) || (id_uses_rt && (s_ex_s.rd == id_rt)));

  // Control priority: reset, then memory freeze, then branch, then load-use.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst_n || !mem_ready) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end else if (branch_taken) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  assign ex_bubble_s = id_ex_bubble | ~id_valid;

  hazard_stage_reg u_s_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mem_ready),
    .bubble_i (ex_bubble_s),
    .d_i      (id_rec_s),
    .q_o      (s_ex_s)
  );

  hazard_stage_reg u_s_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .d_i      (s_ex_s),
    .q_o      (s_mem_s)
  );

  hazard_stage_reg u_s_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .d_i      (s_mem_s),
    .q_o      (s_wb_s)
  );

  // Count advancing load-use stall cycles only. Frozen and branch cycles
  // are excluded, and the count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (mem_ready && !branch_taken && load_use_s &&
        (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ID_EX_rd        = s_ex_s.rd;
  assign EX_MEM_rd       = s_mem_s.rd;
  assign EX_MEM_RegWrite = rec_writes(s_mem_s);
  assign MEM_WB_rd       = s_wb_s.rd;
  assign MEM_WB_RegWrite = rec_writes(s_wb_s);
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (stall counter narrowed to 3 bits so
// saturation is reachable). Inputs change 1 time unit after the rising edge;
// outputs are checked 1 more unit later, well clear of the next edge.
module tb_hazard_stall_unit;

  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid;
  logic [4:0]     id_rs;
  logic [4:0]     id_rt;
  logic           id_uses_rt;
  logic [4:0]     id_rd;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           branch_taken;
  logic           mem_ready;
  logic           pc_write;
  logic           if_id_write;
  logic           if_id_flush;
  logic           id_ex_bubble;
  logic [4:0]     ID_EX_rd;
  logic [4:0]     EX_MEM_rd;
  logic           EX_MEM_RegWrite;
  logic [4:0]     MEM_WB_rd;
  logic           MEM_WB_RegWrite;
  logic [CW-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  hazard_stall_unit #(.STALL_CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ID_EX_rd        (ID_EX_rd),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .MEM_WB_rd       (MEM_WB_rd),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an ID instruction (rs, rt, uses_rt, rd, reg_write, mem_read).
  task automatic id_in(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ut;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the four control outputs {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
  task automatic ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    // Reset state
    ctl("rst_ctl", 4'b0000);
    chk("rst_exrd", {27'd0, ID_EX_rd}, 32'd0);
    chk("rst_memwr", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_wbwr", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("rst_cnt", {29'd0, stall_count}, 32'd0);

    // Load-use on rs
    rst_n = 1'b1;
    id_in(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);         // lw r5
    ctl("lw_issue", 4'b1100);
    tick();
    id_in(5'd5, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);         // add r9, r5, r7
    ctl("lu_stall", 4'b0001);
    chk("lu_exrd", {27'd0, ID_EX_rd}, 32'd5);
    tick();
    chk("lu_cnt1", {29'd0, stall_count}, 32'd1);
    ctl("lu_release", 4'b1100);
    chk("lu_memrd", {27'd0, EX_MEM_rd}, 32'd5);
    chk("lu_memwr", {31'd0, EX_MEM_RegWrite}, 32'd1);
    chk("lu_bubble_ex", {27'd0, ID_EX_rd}, 32'd0);
    tick();
    chk("lu_wbrd", {27'd0, MEM_WB_rd}, 32'd5);
    chk("lu_wbwr", {31'd0, MEM_WB_RegWrite}, 32'd1);
    chk("lu_dep_ex", {27'd0, ID_EX_rd}, 32'd9);

    // No-stall cases
    id_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);         // lw r0
    tick();
    id_in(5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);         // reads r0; itself lw r8
    ctl("ns_rd0", 4'b1100);
    tick();
    id_in(5'd1, 5'd8, 1'b0, 5'd5, 1'b1, 1'b0);         // rt=8 but not used; alu r5
    ctl("ns_rt_unused", 4'b1100);
    chk("ns_memrd0", {27'd0, EX_MEM_rd}, 32'd0);
    tick();
    id_in(5'd5, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);        // reads r5 from alu
    ctl("ns_alu", 4'b1100);
    chk("ns_memrd8", {27'd0, EX_MEM_rd}, 32'd8);
    chk("ns_cnt", {29'd0, stall_count}, 32'd1);
    tick();

    // Branch beats load-use
    id_in(5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);         // lw r6
    tick();
    id_in(5'd6, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    branch_taken = 1'b1; #1;
    ctl("br_ctl", 4'b1111);
    tick();
    branch_taken = 1'b0; #1;
    chk("br_cnt", {29'd0, stall_count}, 32'd1);
    chk("br_exnop", {27'd0, ID_EX_rd}, 32'd0);
    chk("br_memrd", {27'd0, EX_MEM_rd}, 32'd6);

    // Load-use stall stretched by a 3-cycle memory freeze
    id_in(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);         // lw r3
    tick();
    id_in(5'd3, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    mem_ready = 1'b0; #1;
    ctl("fz_ctl0", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      ctl("fz_ctl", 4'b0000);
      chk("fz_exrd", {27'd0, ID_EX_rd}, 32'd3);
      chk("fz_wbrd", {27'd0, MEM_WB_rd}, 32'd6);
      chk("fz_cnt", {29'd0, stall_count}, 32'd1);
    end
    mem_ready = 1'b1; #1;
    ctl("fz_stall", 4'b0001);
    tick();
    chk("fz_cnt2", {29'd0, stall_count}, 32'd2);
    chk("fz_memrd", {27'd0, EX_MEM_rd}, 32'd3);
    ctl("fz_release", 4'b1100);

    // Reset mid-stall
    id_in(5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);         // lw r4
    tick();
    id_in(5'd4, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    ctl("rs_stall", 4'b0001);
    rst_n = 1'b0; #1;
    ctl("rs_ctl", 4'b0000);
    tick();
    chk("rs_cnt", {29'd0, stall_count}, 32'd0);
    chk("rs_exrd", {27'd0, ID_EX_rd}, 32'd0);
    chk("rs_memwr", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rs_wbwr", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("rs_wbrd", {27'd0, MEM_WB_rd}, 32'd0);
    rst_n = 1'b1; #1;
    ctl("rs_after", 4'b1100);

    // Saturation: 9 stalls on a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      id_in(5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);       // lw r2
      tick();
      id_in(5'd2, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
      ctl("sat_stall", 4'b0001);
      tick();
      chk("sat_cnt", {29'd0, stall_count}, (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    chk("sat_final", {29'd0, stall_count}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side companion to data_forwarding_unit in the 5-stage pipeline. It tracks destination-register state for the EX, MEM and WB stages in a shadow pipeline. From that state it drives the EX_MEM_rd/MEM_WB_rd/RegWrite inputs that the forwarding unit consumes. It also detects the load-use hazards that forwarding cannot resolve, and issues the PC/IF-ID stall, ID/EX bubble and branch flush controls. A saturating counter records load-use stall cycles.

Parameters:
REG_ADDR_W, 5, register-specifier width
STALL_CNT_W, 16, width of load-use stall counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  ID source register 1
id_rt  input  REG_ADDR_W  ID source register 2
id_uses_rt  input  1  ID instruction actually reads rt
id_rd  input  REG_ADDR_W  ID destination register
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
branch_taken  input  1  branch resolved taken; held by source until mem_ready=1
mem_ready  input  1  data memory ready; 0 freezes whole pipeline
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register enable
if_id_flush  output  1  clear IF/ID to NOP
id_ex_bubble  output  1  load NOP into ID/EX
ID_EX_rd  output  REG_ADDR_W  rd of instruction in EX
EX_MEM_rd  output  REG_ADDR_W  rd of instruction in MEM
EX_MEM_RegWrite  output  1  RegWrite of instruction in MEM
MEM_WB_rd  output  REG_ADDR_W  rd of instruction in WB
MEM_WB_RegWrite  output  1  RegWrite of instruction in WB
stall_count  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n.
- Shadow stages: S_EX, S_MEM and S_WB. Each stage holds the record {valid, rd, reg_write, mem_read}.
- Reset state:
  - all records are 0 and stall_count=0.
  - while rst_n=0, pc_write=0, if_id_write=0, if_id_flush=0 and id_ex_bubble=0.
- The stage outputs are registered copies of the records: ID_EX_rd=S_EX.rd, EX_MEM_rd=S_MEM.rd, EX_MEM_RegWrite=S_MEM.valid&reg_write, MEM_WB_rd=S_WB.rd, MEM_WB_RegWrite=S_WB.valid&reg_write.
- load_use (combinational) is 1 when all of the following hold:
  - S_EX.valid, S_EX.mem_read and S_EX.reg_write are 1;
  - S_EX.rd != 0;
  - id_valid=1;
  - S_EX.rd==id_rs, or (id_uses_rt=1 and S_EX.rd==id_rt).
- Control priority, highest first:
  - mem_ready=0 (freeze): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0. All shadow records hold. stall_count holds. Pending branch_taken and load_use have no effect this cycle.
  - branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1 (the ID instruction is squashed). load_use is ignored and stall_count does not increment.
  - load_use=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1. stall_count increments by 1, saturating at all-ones.
  - otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Advance rule: on a clock edge with mem_ready=1:
  - S_WB<=S_MEM and S_MEM<=S_EX.
  - S_EX<=0 if id_ex_bubble or !id_valid; otherwise S_EX<={1,id_rd,id_reg_write,id_mem_read}.
- Latency:
  - A load-use stall lasts exactly 1 advancing cycle.
  - On the next advance the load sits in S_MEM and load_use deasserts.
  - The dependent then enters EX while the load is in S_WB, so forwarding selects the MEM/WB path.
- Stall with memory wait: a load-use stall that overlaps mem_ready=0 extends with the freeze. Frozen cycles are not counted.
- rd=0 never causes load_use. Register 0 records still propagate normally.
- Reset asserted mid-operation clears all records on that edge. There is no flush/stall residue after rst_n returns to 1.

Decomposition:
- Package hazard_pkg holds:
  - REG_ADDR_W;
  - the stage_rec_t struct {valid, rd, reg_write, mem_read};
  - the STAGE_NOP constant (all zeros).
- One natural sub-module is hazard_stage_reg. It is the per-stage record register with synchronous active-low clear, hold enable and bubble-load, instantiated three times.

Test Plan:
- Load-use on rs: lw rd=5 in S_EX, ID add rs=5 rt=7 id_uses_rt=1, mem_ready=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count 0->1. Next cycle no stall; two edges later MEM_WB_rd=5 and MEM_WB_RegWrite=1.
- No stall cases: lw rd=0 with ID rs=0 -> no stall. Load rd=8 with ID rt=8 and id_uses_rt=0 -> no stall. ALU op (mem_read=0) rd=5 with ID rs=5 -> no stall.
- Branch vs load-use same cycle: load-use condition plus branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_count unchanged; S_EX becomes NOP after the edge.
- Memory freeze: mem_ready=0 for 3 cycles during a load-use stall -> records hold and stall_count holds. Controls stay frozen (all enables 0). The stall completes on the first mem_ready=1 cycle and counts once.
- Saturation: preload via 2^16 stall cycles (or STALL_CNT_W=3 with 9 stalls) -> stall_count stays at all-ones.
- Reset mid-stall: rst_n=0 for 1 edge while load_use is active -> all outputs 0, EX_MEM_RegWrite=0, MEM_WB_RegWrite=0, stall_count=0.
